// File: rtl/multi_ctrl_fsm_pkg.sv
// multi_ctrl_fsm_pkg: state codes, opcodes and control encodings shared with the ALU-control decoder.
package multi_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/multi_ctrl_fsm.sv
// multi_ctrl_fsm: multicycle MIPS-style main control FSM (fetch/decode/execute/memory/write-back).
// Define MULTI_CTRL_ADDI_EN to add addi support (ADDIEX/ADDIWB); otherwise addi decodes as illegal.
module multi_ctrl_fsm
    import multi_ctrl_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               ir_write,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    if (STATE_W < 4) begin : g_bad_width
        $error("multi_ctrl_fsm: STATE_W must be at least 4");
    end

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = STATE_W'(state_q);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_source     = PC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BROFF;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
                state_d   = S_FETCH;
            end
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            // Unreachable codes recover to FETCH with every output deasserted.
            default: state_d = S_FETCH;
        endcase
    end

endmodule
